// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame line levels and the parity helper.
package uart_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALIGN  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above i_ptr, wrapping.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_gnt_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    // Scan from the pointer upward; the first hit wins.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            if (i_en && !w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_gnt[w_idx]   = 1'b1;
                o_gnt_idx      = w_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin UART transmit scheduler: NUM_REQ byte sources share one 8N1 tx line.
// Define UART_TX_SCHED_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   baud_tick,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   frame_done
);

    uart_state_t            r_state;
    logic [DATA_BITS-1:0]   r_shreg;
    logic [3:0]             r_bitcnt;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [IDX_W-1:0]       r_grant_id;
    logic                   r_tx;
    logic                   r_busy;
    logic                   r_frame_done;
`ifdef UART_TX_SCHED_PARITY_EN
    logic                   r_par;
`endif

    logic [NUM_REQ-1:0]     w_gnt;
    logic [IDX_W-1:0]       w_gnt_idx;
    logic [DATA_BITS-1:0]   w_byte;
    logic [IDX_W-1:0]       w_next_ptr;
    logic                   w_accept;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req     (req_valid),
        .i_ptr     (r_rr_ptr),
        .i_en      (r_state == ST_IDLE),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign req_ready  = w_gnt;
    assign w_accept   = |w_gnt;
    assign w_next_ptr = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : (w_gnt_idx + IDX_W'(1));

    // Select the granted source's byte.
    always_comb begin
        w_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_byte = req_data[8*i +: 8];
            end else begin
                w_byte = w_byte;
            end
        end
    end

    // Frame FSM; tx only moves on baud_tick, and a tick in the accept cycle is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_bitcnt     <= 4'd0;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_tx         <= IDLE_LEVEL;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef UART_TX_SCHED_PARITY_EN
            r_par        <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shreg    <= w_byte;
                        r_grant_id <= w_gnt_idx;
                        r_rr_ptr   <= w_next_ptr;
                        r_busy     <= 1'b1;
                        r_tx       <= IDLE_LEVEL;
                        r_state    <= ST_ALIGN;
`ifdef UART_TX_SCHED_PARITY_EN
                        r_par      <= even_parity(w_byte);
`endif
                    end
                end
                ST_ALIGN: begin
                    if (baud_tick) begin
                        r_tx    <= START_LEVEL;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        r_tx     <= r_shreg[0];
                        r_shreg  <= {1'b0, r_shreg[DATA_BITS-1:1]};
                        r_bitcnt <= 4'd1;
                        r_state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (r_bitcnt < 4'(DATA_BITS)) begin
                            r_tx     <= r_shreg[0];
                            r_shreg  <= {1'b0, r_shreg[DATA_BITS-1:1]};
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else begin
`ifdef UART_TX_SCHED_PARITY_EN
                            r_tx    <= r_par;
                            r_state <= ST_PARITY;
`else
                            r_tx    <= STOP_LEVEL;
                            r_state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_SCHED_PARITY_EN
                ST_PARITY: begin
                    if (baud_tick) begin
                        r_tx    <= STOP_LEVEL;
                        r_state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_tick) begin
                        r_frame_done <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_tx    <= IDLE_LEVEL;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign grant_id   = r_grant_id;
    assign frame_done = r_frame_done;

endmodule
